// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared constants for the MIPS pipeline
package mips_defs;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [WORD_W-1:0] IM_BASE_DEFAULT  = 32'h0000_3000;

endpackage

// File: rtl/instr_rom.sv
// rtl/instr_rom.sv - instruction ROM with combinational word read
module instr_rom
  import mips_defs::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0]     addr_i,
  output logic [WORD_W-1:0] rdata_o
);

  // Contents are preloaded from outside (boot image / bench), never written here.
  logic [WORD_W-1:0] Instr_memory [0:DEPTH-1];

  assign rdata_o = Instr_memory[addr_i];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, ROM fetch and IF/ID pipeline register
module fetch_stage
  import mips_defs::*;
#(
  parameter int unsigned       IM_DEPTH = 1024,
  parameter logic [WORD_W-1:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter logic [WORD_W-1:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic [WORD_W-1:0] pc_f,
  output logic [WORD_W-1:0] instr_d,
  output logic [WORD_W-1:0] pc_d,
  output logic [WORD_W-1:0] pc4_d,
  output logic              valid_d,
  output logic              fetch_err_d
);

  localparam int unsigned   AW       = $clog2(IM_DEPTH);
  localparam logic [WORD_W:0] IM_SPAN  = (WORD_W+1)'(IM_DEPTH) << 2;
  localparam logic [WORD_W:0] IM_LIMIT = {1'b0, IM_BASE} + IM_SPAN;

  logic [WORD_W-1:0] fpc_q, fpc_d;
  logic [WORD_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [WORD_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [WORD_W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              ifid_err_q, ifid_err_d;

  logic [AW-1:0]     rom_addr;
  logic [WORD_W-1:0] rom_word;
  logic [WORD_W-1:0] fetch_word;
  logic [WORD_W-1:0] pc_plus4;
  logic              fetch_err;

  instr_rom #(
    .DEPTH (IM_DEPTH),
    .AW    (AW)
  ) myIM (
    .addr_i  (rom_addr),
    .rdata_o (rom_word)
  );

  // Range compare is done at WORD_W+1 bits so a ROM ending at 4 GiB still works.
  always_comb begin
    rom_addr   = AW'((fpc_q - IM_BASE) >> 2);
    pc_plus4   = fpc_q + 32'd4;
    fetch_err  = (fpc_q[1:0] != 2'b00)
              || ({1'b0, fpc_q} < {1'b0, IM_BASE})
              || ({1'b0, fpc_q} >= IM_LIMIT);
    fetch_word = fetch_err ? NOP_INSTR : rom_word;
  end

  always_comb begin
    fpc_d = pc_plus4;
    if (stall) begin
      fpc_d = fpc_q;
    end else if (redirect_valid) begin
      fpc_d = redirect_pc;
    end
  end

  // Redirects never bubble IF/ID: the word fetched alongside is the delay slot.
  always_comb begin
    ifid_instr_d = fetch_word;
    ifid_pc_d    = fpc_q;
    ifid_pc4_d   = pc_plus4;
    ifid_valid_d = 1'b1;
    ifid_err_d   = fetch_err;
    if (flush) begin
      ifid_instr_d = NOP_INSTR;
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      ifid_valid_d = 1'b0;
      ifid_err_d   = 1'b0;
    end else if (stall) begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_pc4_d   = ifid_pc4_q;
      ifid_valid_d = ifid_valid_q;
      ifid_err_d   = ifid_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q        <= PC_RESET;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      ifid_err_q   <= 1'b0;
    end else begin
      fpc_q        <= fpc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_err_q   <= ifid_err_d;
    end
  end

  assign pc_f        = fpc_q;
  assign instr_d     = ifid_instr_q;
  assign pc_d        = ifid_pc_q;
  assign pc4_d       = ifid_pc4_q;
  assign valid_d     = ifid_valid_q;
  assign fetch_err_d = ifid_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_f, instr_d, pc_d, pc4_d;
  logic        valid_d, fetch_err_d;

  int checks = 0;
  int failures = 0;

  fetch_stage #(
    .IM_DEPTH (1024),
    .IM_BASE  (32'h0000_3000),
    .PC_RESET (32'h0000_3000)
  ) my_CPU (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_f           (pc_f),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc4_d          (pc4_d),
    .valid_d        (valid_d),
    .fetch_err_d    (fetch_err_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample 1ns after the rising edge.
  task automatic step(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    stall          = st;
    flush          = fl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_instr,
                              input logic [31:0] e_pcd, input logic e_valid, input logic e_err);
    logic [31:0] e_pc4;
    e_pc4 = e_valid ? e_pcd + 32'd4 : 32'h0;
    chk({tag, ".pc_f"},        pc_f,                 e_pcf);
    chk({tag, ".instr_d"},     instr_d,              e_instr);
    chk({tag, ".pc_d"},        pc_d,                 e_pcd);
    chk({tag, ".pc4_d"},       pc4_d,                e_pc4);
    chk({tag, ".valid_d"},     {31'h0, valid_d},     {31'h0, e_valid});
    chk({tag, ".fetch_err_d"}, {31'h0, fetch_err_d}, {31'h0, e_err});
  endtask

  function automatic logic [31:0] aw(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) my_CPU.myIM.Instr_memory[i] = aw(i);
    my_CPU.myIM.Instr_memory[0] = 32'h2401_0001;
    my_CPU.myIM.Instr_memory[1] = 32'h2402_0002;
    my_CPU.myIM.Instr_memory[2] = 32'h2403_0003;

    reset = 1'b1;
    step(0, 0, 0, 32'h0);
    expect_state("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    step(0, 0, 0, 32'h0);
    expect_state("run0", 32'h3004, 32'h2401_0001, 32'h3000, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0);
    expect_state("run1", 32'h3008, 32'h2402_0002, 32'h3004, 1'b1, 1'b0);

    step(1, 0, 0, 32'h0);
    expect_state("stall0", 32'h3008, 32'h2402_0002, 32'h3004, 1'b1, 1'b0);
    step(1, 0, 0, 32'h0);
    expect_state("stall1", 32'h3008, 32'h2402_0002, 32'h3004, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0);
    expect_state("resume", 32'h300C, 32'h2403_0003, 32'h3008, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0);
    expect_state("run3", 32'h3010, aw(3), 32'h300C, 1'b1, 1'b0);

    step(0, 0, 1, 32'h3100);
    expect_state("redir_slot", 32'h3100, aw(4), 32'h3010, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0);
    expect_state("redir_tgt", 32'h3104, aw(32'h40), 32'h3100, 1'b1, 1'b0);

    step(0, 1, 0, 32'h0);
    expect_state("flush", 32'h3108, 32'h0, 32'h0, 1'b0, 1'b0);
    step(0, 0, 0, 32'h0);
    expect_state("post_flush", 32'h310C, aw(32'h42), 32'h3108, 1'b1, 1'b0);

    step(1, 1, 0, 32'h0);
    expect_state("flush_stall", 32'h310C, 32'h0, 32'h0, 1'b0, 1'b0);
    step(0, 0, 0, 32'h0);
    expect_state("post_fs", 32'h3110, aw(32'h43), 32'h310C, 1'b1, 1'b0);

    step(1, 0, 1, 32'h3200);
    expect_state("stall_redir", 32'h3110, aw(32'h43), 32'h310C, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0);
    expect_state("post_sr", 32'h3114, aw(32'h44), 32'h3110, 1'b1, 1'b0);

    step(0, 0, 1, 32'h3002);
    expect_state("to_misalign", 32'h3002, aw(32'h45), 32'h3114, 1'b1, 1'b0);
    step(0, 0, 1, 32'h3FFC);
    expect_state("misalign", 32'h3FFC, 32'h0, 32'h3002, 1'b1, 1'b1);
    step(0, 0, 0, 32'h0);
    expect_state("last_word", 32'h4000, aw(1023), 32'h3FFC, 1'b1, 1'b0);
    step(0, 0, 1, 32'h5000);
    expect_state("past_end", 32'h5000, 32'h0, 32'h4000, 1'b1, 1'b1);
    step(0, 0, 1, 32'h2FFC);
    expect_state("far_past", 32'h2FFC, 32'h0, 32'h5000, 1'b1, 1'b1);
    step(0, 0, 1, 32'hFFFF_FFFC);
    expect_state("below_base", 32'hFFFF_FFFC, 32'h0, 32'h2FFC, 1'b1, 1'b1);
    step(0, 0, 1, 32'h3000);
    expect_state("wrap", 32'h3000, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(0, 0, 0, 32'h0);
    expect_state("back0", 32'h3004, 32'h2401_0001, 32'h3000, 1'b1, 1'b0);
    step(0, 0, 0, 32'h0);
    expect_state("back1", 32'h3008, 32'h2402_0002, 32'h3004, 1'b1, 1'b0);

    reset = 1'b1;
    step(1, 1, 1, 32'h3100);
    expect_state("mid_reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    step(0, 0, 0, 32'h0);
    expect_state("after_reset", 32'h3004, 32'h2401_0001, 32'h3000, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
